// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the EX/MEM stage.
//   seq_state_e            - data-memory sequencer state (IDLE / BUSY)
//   WB_* / M_* indices     - bit positions inside the WB and M control fields
//   DEFAULT_TIMEOUT_CYCLES - default request timeout (used with DMEM_TIMEOUT_EN)
package pipeline_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned M_READ      = 1;
  localparam int unsigned M_WRITE     = 0;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/dmem_sequencer.sv
// dmem_sequencer: request/acknowledge sequencer for data memory.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no memory access outstanding; EX stage is captured each edge
// BUSY    | request held on the bus, upstream frozen until ack (or abort)
//
// Optional feature macro: DMEM_TIMEOUT_EN adds an 8-bit request timer that
// aborts the access after TIMEOUT_CYCLES un-acked cycles and sets a sticky
// error flag. Without the macro BUSY waits indefinitely and err_o is 0.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i      - captured instruction needs memory (sampled in IDLE)
//   write_i      - access is a store (sampled with start_i)
//   dmem_ack_i   - memory completion (only meaningful in BUSY)
//   busy_o       - state is BUSY (drives stall)
//   dmem_req_o   - registered memory request
//   dmem_we_o    - registered write enable
//   ack_done_o   - completion on this edge
//   timeout_o    - abort on this edge
//   err_o        - sticky timeout flag
module dmem_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic write_i,
  input  logic dmem_ack_i,
  output logic busy_o,
  output logic dmem_req_o,
  output logic dmem_we_o,
  output logic ack_done_o,
  output logic timeout_o,
  output logic err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dmem_sequencer: TIMEOUT_CYCLES must be within 1..255");
  end

  seq_state_e state_q;
  logic       req_q;
  logic       we_q;

  assign busy_o     = (state_q == ST_BUSY);
  assign ack_done_o = busy_o & dmem_ack_i;
  assign dmem_req_o = req_q;
  assign dmem_we_o  = we_q;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic       err_q;

  // The edge that would take the count to TIMEOUT_CYCLES is the abort edge;
  // an ack on that same edge takes priority.
  assign timeout_o = busy_o & ~dmem_ack_i & (cnt_q == LAST_CNT);
  assign err_o     = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // Held at zero in IDLE so every BUSY period starts from a clean count.
      if (!busy_o) begin
        cnt_q <= '0;
      end else if (!dmem_ack_i) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (timeout_o) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_o = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_BUSY;
            req_q   <= 1'b1;
            we_q    <= write_i;
          end
        end
        ST_BUSY: begin
          if (dmem_ack_i || timeout_o) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register of the RV32 core.
// Latches the EX result and WB control, runs loads/stores against data
// memory through dmem_sequencer, and stalls upstream while an access is
// outstanding. Optional feature macro: DMEM_TIMEOUT_EN (request timeout
// with sticky err_o; see dmem_sequencer).
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   valid_i, WB_i, M_i, alu_result_i, wr_data_i, rd_i   - from EX
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o     - to data memory
//   dmem_ack_i, dmem_rdata_i                             - from data memory
//   stall_o                                              - freeze IF/ID, ID/EX
//   valid_o, WB_o, rd_o, alu_result_o, mem_rdata_o       - to MEM/WB
//   fwd_regwrite_o, fwd_rd_o                             - to forwarding unit
//   err_o                                                - sticky timeout flag
module ex_mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  WB_i,
  input  logic [1:0]  M_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] wr_data_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [1:0]  WB_o,
  output logic [4:0]  rd_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_rdata_o,
  output logic        fwd_regwrite_o,
  output logic [4:0]  fwd_rd_o,
  output logic        err_o
);

  logic busy;
  logic ack_done;
  logic timeout;
  logic is_mem;

  logic        valid_cap_d, valid_cap_q;
  logic        valid_out_d, valid_out_q;
  logic [1:0]  wb_d, wb_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] alu_d, alu_q;
  logic [31:0] wdata_d, wdata_q;
  logic [31:0] rdata_d, rdata_q;

  // MemRead and MemWrite both set is a store: write_i takes M_WRITE alone.
  assign is_mem = valid_i & (M_i[M_READ] | M_i[M_WRITE]);

  dmem_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (is_mem),
    .write_i    (M_i[M_WRITE]),
    .dmem_ack_i (dmem_ack_i),
    .busy_o     (busy),
    .dmem_req_o (dmem_req_o),
    .dmem_we_o  (dmem_we_o),
    .ack_done_o (ack_done),
    .timeout_o  (timeout),
    .err_o      (err_o)
  );

  always_comb begin
    valid_cap_d = valid_cap_q;
    valid_out_d = valid_out_q;
    wb_d        = wb_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    if (!busy) begin
      valid_cap_d = valid_i;
      wb_d        = WB_i;
      rd_d        = rd_i;
      alu_d       = alu_result_i;
      wdata_d     = wr_data_i;
      // Memory ops retire later, when the access finishes.
      valid_out_d = valid_i & ~is_mem;
    end else begin
      valid_out_d = ack_done | timeout;
      // An aborted access must not write back a bogus register value.
      if (timeout) begin
        wb_d = 2'b00;
      end
      if (ack_done && !dmem_we_o) begin
        rdata_d = dmem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_cap_q <= 1'b0;
      valid_out_q <= 1'b0;
      wb_q        <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      valid_cap_q <= valid_cap_d;
      valid_out_q <= valid_out_d;
      wb_q        <= wb_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall_o        = busy;
  assign valid_o        = valid_out_q;
  assign WB_o           = wb_q;
  assign rd_o           = rd_q;
  assign alu_result_o   = alu_q;
  assign mem_rdata_o    = rdata_q;
  assign dmem_addr_o    = alu_q;
  assign dmem_wdata_o   = wdata_q;
  assign fwd_regwrite_o = wb_q[WB_REGWRITE] & valid_cap_q;
  assign fwd_rd_o       = rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  WB_i;
  logic [1:0]  M_i;
  logic [31:0] alu_result_i;
  logic [31:0] wr_data_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        valid_o;
  logic [1:0]  WB_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_result_o;
  logic [31:0] mem_rdata_o;
  logic        fwd_regwrite_o;
  logic [4:0]  fwd_rd_o;
  logic        err_o;

  int n_pass  = 0;
  int n_total = 0;

  ex_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .WB_i           (WB_i),
    .M_i            (M_i),
    .alu_result_i   (alu_result_i),
    .wr_data_i      (wr_data_i),
    .rd_i           (rd_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ack_i     (dmem_ack_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_o        (stall_o),
    .valid_o        (valid_o),
    .WB_o           (WB_o),
    .rd_o           (rd_o),
    .alu_result_o   (alu_result_o),
    .mem_rdata_o    (mem_rdata_o),
    .fwd_regwrite_o (fwd_regwrite_o),
    .fwd_rd_o       (fwd_rd_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] m,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    valid_i      = v;
    WB_i         = wb;
    M_i          = m;
    alu_result_i = alu;
    wr_data_i    = wd;
    rd_i         = rd;
  endtask

  task automatic scramble();
    drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  task automatic do_reset();
    rst_i      = 1'b0;
    dmem_ack_i = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i        = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    drive(1'b1, 2'b11, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    tick();
    tick();
    n_total++; if (valid_o !== 1'b0) $display("FAIL rst_valid got %0b exp 0", valid_o); else n_pass++;
    n_total++; if (dmem_req_o !== 1'b0) $display("FAIL rst_req got %0b exp 0", dmem_req_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL rst_stall got %0b exp 0", stall_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err got %0b exp 0", err_o); else n_pass++;
    n_total++; if ({WB_o, rd_o, alu_result_o, mem_rdata_o, fwd_regwrite_o, fwd_rd_o, dmem_addr_o, dmem_wdata_o, dmem_we_o} !== '0)
      $display("FAIL rst_regs got nonzero wb=%0h rd=%0d alu=%0h rdata=%0h", WB_o, rd_o, alu_result_o, mem_rdata_o);
    else n_pass++;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    rst_i = 1'b1;
  endtask

  task automatic test_add();
    drive(1'b1, 2'b10, 2'b00, 32'h10, 32'h99, 5'd5);
    tick();
    n_total++; if (valid_o !== 1'b1) $display("FAIL add_valid got %0b exp 1", valid_o); else n_pass++;
    n_total++; if (alu_result_o !== 32'h10) $display("FAIL add_alu got %0h exp 10", alu_result_o); else n_pass++;
    n_total++; if (rd_o !== 5'd5) $display("FAIL add_rd got %0d exp 5", rd_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL add_stall got %0b exp 0", stall_o); else n_pass++;
    n_total++; if (dmem_req_o !== 1'b0) $display("FAIL add_req got %0b exp 0", dmem_req_o); else n_pass++;
    n_total++; if ({fwd_regwrite_o, fwd_rd_o} !== {1'b1, 5'd5}) $display("FAIL add_fwd got %0b/%0d exp 1/5", fwd_regwrite_o, fwd_rd_o); else n_pass++;
    drive(1'b0, 2'b10, 2'b00, 32'h20, 32'h0, 5'd6);
    tick();
    n_total++; if (valid_o !== 1'b0) $display("FAIL bubble_valid got %0b exp 0", valid_o); else n_pass++;
    n_total++; if (fwd_regwrite_o !== 1'b0) $display("FAIL bubble_fwd got %0b exp 0", fwd_regwrite_o); else n_pass++;
  endtask

  task automatic test_load();
    drive(1'b1, 2'b11, 2'b10, 32'h40, 32'h0, 5'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      scramble();
      n_total++; if ({stall_o, dmem_req_o, dmem_we_o, valid_o} !== 4'b1100)
        $display("FAIL lw_busy%0d got stall/req/we/valid=%b exp 1100", i, {stall_o, dmem_req_o, dmem_we_o, valid_o});
      else n_pass++;
      n_total++; if (dmem_addr_o !== 32'h40) $display("FAIL lw_addr%0d got %0h exp 40", i, dmem_addr_o); else n_pass++;
      n_total++; if ({fwd_regwrite_o, fwd_rd_o} !== {1'b1, 5'd7}) $display("FAIL lw_fwd%0d got %0b/%0d exp 1/7", i, fwd_regwrite_o, fwd_rd_o); else n_pass++;
      if (i == 2) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
      end
      tick();
    end
    dmem_ack_i = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    n_total++; if ({valid_o, stall_o, dmem_req_o} !== 3'b100) $display("FAIL lw_done got valid/stall/req=%b exp 100", {valid_o, stall_o, dmem_req_o}); else n_pass++;
    n_total++; if (mem_rdata_o !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %0h exp deadbeef", mem_rdata_o); else n_pass++;
    n_total++; if ({WB_o, rd_o} !== {2'b11, 5'd7}) $display("FAIL lw_wbrd got %b/%0d exp 11/7", WB_o, rd_o); else n_pass++;
    tick();
    n_total++; if (valid_o !== 1'b0) $display("FAIL lw_pulse got %0b exp 0", valid_o); else n_pass++;
  endtask

  task automatic test_store();
    drive(1'b1, 2'b00, 2'b01, 32'h44, 32'h1234, 5'd0);
    tick();
    n_total++; if ({dmem_req_o, dmem_we_o, stall_o} !== 3'b111) $display("FAIL sw_req got req/we/stall=%b exp 111", {dmem_req_o, dmem_we_o, stall_o}); else n_pass++;
    drive(1'b1, 2'b10, 2'b10, 32'h0, 32'hFFFF, 5'd3);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h5555_AAAA;
    #1;
    n_total++; if ({dmem_addr_o, dmem_wdata_o} !== {32'h44, 32'h1234}) $display("FAIL sw_hold got %0h/%0h exp 44/1234", dmem_addr_o, dmem_wdata_o); else n_pass++;
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    n_total++; if ({valid_o, dmem_req_o, stall_o} !== 3'b100) $display("FAIL sw_done got valid/req/stall=%b exp 100", {valid_o, dmem_req_o, stall_o}); else n_pass++;
    n_total++; if (mem_rdata_o !== 32'hDEAD_BEEF) $display("FAIL sw_rdata got %0h exp deadbeef", mem_rdata_o); else n_pass++;
    // ack held while idle must be ignored
    tick();
    n_total++; if ({valid_o, dmem_req_o, stall_o} !== 3'b000) $display("FAIL idle_ack got valid/req/stall=%b exp 000", {valid_o, dmem_req_o, stall_o}); else n_pass++;
    n_total++; if (mem_rdata_o !== 32'hDEAD_BEEF) $display("FAIL idle_ack_rdata got %0h exp deadbeef", mem_rdata_o); else n_pass++;
    dmem_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 2'b11, 2'b10, 32'h80, 32'h0, 5'd9);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    n_total++; if (dmem_req_o !== 1'b1) $display("FAIL rstb_pre got %0b exp 1", dmem_req_o); else n_pass++;
    rst_i = 1'b0;
    #1;
    n_total++; if ({dmem_req_o, stall_o, valid_o} !== 3'b000) $display("FAIL rstb_async got req/stall/valid=%b exp 000", {dmem_req_o, stall_o, valid_o}); else n_pass++;
    tick();
    rst_i = 1'b1;
    drive(1'b1, 2'b10, 2'b00, 32'h31, 32'h0, 5'd12);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    n_total++; if ({valid_o, stall_o, rd_o, alu_result_o} !== {1'b1, 1'b0, 5'd12, 32'h31})
      $display("FAIL rstb_add got valid=%0b stall=%0b rd=%0d alu=%0h exp 1 0 12 31", valid_o, stall_o, rd_o, alu_result_o);
    else n_pass++;
  endtask

  // Transaction-level reference: each instruction retires once with its own
  // fields; loads replace the last read data, everything else leaves it.
  task automatic test_random();
    logic        v;
    logic [1:0]  wb, m;
    logic [31:0] alu, wd, rdata, exp_rdata;
    logic [4:0]  rd;
    int          lat;
    bit          mem;
    do_reset();
    exp_rdata = 32'h0;
    for (int n = 0; n < 40; n++) begin
      v   = 1'($urandom_range(0, 3) != 0);
      wb  = 2'($urandom_range(0, 3));
      m   = 2'($urandom_range(0, 3));
      alu = $urandom;
      wd  = $urandom;
      rd  = 5'($urandom_range(0, 31));
      lat = $urandom_range(1, 3);
      mem = v && (m != 2'b00);
      rdata = $urandom;
      drive(v, wb, m, alu, wd, rd);
      dmem_ack_i   = 1'($urandom_range(0, 1));
      dmem_rdata_i = $urandom;
      tick();
      dmem_ack_i = 1'b0;
      if (mem) begin
        for (int i = 0; i < lat; i++) begin
          scramble();
          n_total++; if ({stall_o, dmem_req_o, dmem_we_o, valid_o} !== {1'b1, 1'b1, m[0], 1'b0})
            $display("FAIL rnd%0d_busy got stall/req/we/valid=%b exp 11%0b0", n, {stall_o, dmem_req_o, dmem_we_o, valid_o}, m[0]);
          else n_pass++;
          n_total++; if ({dmem_addr_o, dmem_wdata_o} !== {alu, wd})
            $display("FAIL rnd%0d_bus got %0h/%0h exp %0h/%0h", n, dmem_addr_o, dmem_wdata_o, alu, wd);
          else n_pass++;
          if (i == lat - 1) begin
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = rdata;
          end
          tick();
        end
        dmem_ack_i = 1'b0;
        if (!m[0]) exp_rdata = rdata;
      end
      n_total++; if ({valid_o, stall_o, dmem_req_o} !== {v, 1'b0, 1'b0})
        $display("FAIL rnd%0d_ret got valid/stall/req=%b exp %0b00", n, {valid_o, stall_o, dmem_req_o}, v);
      else n_pass++;
      n_total++; if ({WB_o, rd_o, alu_result_o} !== {wb, rd, alu})
        $display("FAIL rnd%0d_fields got %b/%0d/%0h exp %b/%0d/%0h", n, WB_o, rd_o, alu_result_o, wb, rd, alu);
      else n_pass++;
      n_total++; if (mem_rdata_o !== exp_rdata) $display("FAIL rnd%0d_rdata got %0h exp %0h", n, mem_rdata_o, exp_rdata); else n_pass++;
      n_total++; if ({fwd_regwrite_o, fwd_rd_o} !== {wb[1] & v, rd})
        $display("FAIL rnd%0d_fwd got %0b/%0d exp %0b/%0d", n, fwd_regwrite_o, fwd_rd_o, wb[1] & v, rd);
      else n_pass++;
    end
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive(1'b1, 2'b11, 2'b10, 32'h80, 32'h0, 5'd9);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({dmem_req_o, err_o} !== 2'b10) $display("FAIL to_wait%0d got req/err=%b exp 10", i, {dmem_req_o, err_o}); else n_pass++;
      tick();
    end
    n_total++; if ({dmem_req_o, stall_o, valid_o, err_o} !== 4'b0011)
      $display("FAIL to_abort got req/stall/valid/err=%b exp 0011", {dmem_req_o, stall_o, valid_o, err_o});
    else n_pass++;
    n_total++; if ({WB_o, fwd_regwrite_o} !== 3'b000) $display("FAIL to_wb got %b/%0b exp 00/0", WB_o, fwd_regwrite_o); else n_pass++;
    tick();
    n_total++; if ({valid_o, err_o} !== 2'b01) $display("FAIL to_sticky got valid/err=%b exp 01", {valid_o, err_o}); else n_pass++;
    do_reset();
    drive(1'b1, 2'b11, 2'b10, 32'h84, 32'h0, 5'd10);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hCAFE_F00D;
      end
      tick();
    end
    dmem_ack_i = 1'b0;
    n_total++; if ({valid_o, err_o, WB_o} !== 4'b1011) $display("FAIL to_ackwins got valid/err/wb=%b exp 1011", {valid_o, err_o, WB_o}); else n_pass++;
    n_total++; if (mem_rdata_o !== 32'hCAFE_F00D) $display("FAIL to_ackwins_rdata got %0h exp cafef00d", mem_rdata_o); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    drive(1'b1, 2'b10, 2'b10, 32'h88, 32'h0, 5'd4);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 8; i++) tick();
    n_total++; if ({dmem_req_o, stall_o, valid_o, err_o} !== 4'b1100)
      $display("FAIL nto_wait got req/stall/valid/err=%b exp 1100", {dmem_req_o, stall_o, valid_o, err_o});
    else n_pass++;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0BAD_CAFE;
    tick();
    dmem_ack_i = 1'b0;
    n_total++; if ({valid_o, err_o, WB_o, mem_rdata_o} !== {1'b1, 1'b0, 2'b10, 32'h0BAD_CAFE})
      $display("FAIL nto_done got valid=%0b err=%0b wb=%b rdata=%0h", valid_o, err_o, WB_o, mem_rdata_o);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_reset_mid_busy();
    test_random();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
